// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store AHB-Lite data port: bus encodings,
// access sizes, FSM states and small lane helpers.
package lsu_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [1:0] LS_SIZE_B = 2'b00;
   localparam logic [1:0] LS_SIZE_H = 2'b01;
   localparam logic [1:0] LS_SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_DATA = 2'b01,
      LSU_ERR  = 2'b10
   } lsu_state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      return ((size == LS_SIZE_H) && lo[0]) || ((size == LS_SIZE_W) && (lo != 2'b00));
   endfunction

   // Forces the low address bits onto the natural boundary of the access size.
   function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         LS_SIZE_H: return {lo[1], 1'b0};
         LS_SIZE_W: return 2'b00;
         default:   return lo;
      endcase
   endfunction

   function automatic logic [31:0] replicate_lanes(input logic [1:0] size, input logic [31:0] data);
      case (size)
         LS_SIZE_B: return {4{data[7:0]}};
         LS_SIZE_H: return {2{data[15:0]}};
         default:   return data;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select plus sign/zero extension from a 32-bit bus word;
// purely combinational so a future D-cache can reuse it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] hrdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      byte_sel = hrdata_i[7:0];
      case (addr_lo_i)
         2'd1:    byte_sel = hrdata_i[15:8];
         2'd2:    byte_sel = hrdata_i[23:16];
         2'd3:    byte_sel = hrdata_i[31:24];
         default: byte_sel = hrdata_i[7:0];
      endcase
      half_sel = addr_lo_i[1] ? hrdata_i[31:16] : hrdata_i[15:0];

      data_o = hrdata_i;
      case (size_i)
         LS_SIZE_B: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         LS_SIZE_H: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default:   data_o = hrdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_ahb_dport.sv
// Load/store AHB-Lite data-port master: one transfer per memory instruction,
// address/data pipelined. Misaligned-access trapping enabled by LSU_MISALIGN_TRAP_EN.
module lsu_ahb_dport
   import lsu_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ls_valid,
   input  logic          ls_store,
   input  logic [1:0]    ls_size,
   input  logic          ls_unsigned,
   input  logic [4:0]    ls_rd,
   input  logic [AW-1:0] addr_res,
   input  logic [DW-1:0] st_data,
   output logic [AW-1:0] d_haddr,
   output logic [1:0]    d_htrans,
   output logic          d_hwrite,
   output logic [2:0]    d_hsize,
   output logic [DW-1:0] d_hwdata,
   input  logic [DW-1:0] d_hrdata,
   input  logic          d_hready,
   input  logic          d_hresp,
   output logic          ls_stall,
   output logic          wb_valid,
   output logic [4:0]    wb_rd,
   output logic [DW-1:0] wb_data,
   output logic          misalign_exc,
   output logic          bus_err_exc
);

   lsu_state_e    state_q;
   logic          store_q;
   logic          unsigned_q;
   logic [1:0]    size_q;
   logic [1:0]    addr_lo_q;
   logic [4:0]    rd_q;
   logic [DW-1:0] wdata_q;

   logic          wb_valid_q;
   logic [4:0]    wb_rd_q;
   logic [DW-1:0] wb_data_q;
   logic          misalign_exc_q;
   logic          bus_err_exc_q;

   logic          misaligned;
   logic [1:0]    addr_lo_d;
   logic          slot_free;
   logic          data_ok;
   logic          accept;
   logic          misalign_take;
   logic [DW-1:0] load_data;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = is_misaligned(ls_size, addr_res[1:0]);
   assign addr_lo_d  = addr_res[1:0];
`else
   assign misaligned = 1'b0;
   assign addr_lo_d  = align_lo(ls_size, addr_res[1:0]);
`endif

   // A new address phase may issue from IDLE or alongside a clean data-phase completion.
   assign data_ok       = (state_q == LSU_DATA) & d_hready & ~d_hresp;
   assign slot_free     = (state_q == LSU_IDLE) | data_ok;
   assign accept        = ls_valid & ~misaligned & slot_free;
   assign misalign_take = ls_valid & misaligned & slot_free;

   assign d_htrans = accept ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign d_haddr  = accept ? {addr_res[AW-1:2], addr_lo_d} : '0;
   assign d_hwrite = accept & ls_store;
   assign d_hsize  = accept ? {1'b0, ls_size} : 3'b000;
   assign d_hwdata = replicate_lanes(size_q, wdata_q);

   assign ls_stall = ((state_q == LSU_DATA) & ~d_hready) | (state_q == LSU_ERR) |
                     ((state_q == LSU_DATA) & d_hresp);

   assign wb_valid     = wb_valid_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign misalign_exc = misalign_exc_q;
   assign bus_err_exc  = bus_err_exc_q;

   lsu_load_align u_align (
      .hrdata_i   (d_hrdata),
      .addr_lo_i  (addr_lo_q),
      .size_i     (size_q),
      .unsigned_i (unsigned_q),
      .data_o     (load_data)
   );

   // NOTE: reset is synchronous here, so rst_n is only tested inside the clocked branch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= LSU_IDLE;
         store_q        <= 1'b0;
         unsigned_q     <= 1'b0;
         size_q         <= 2'b00;
         addr_lo_q      <= 2'b00;
         rd_q           <= 5'd0;
         wdata_q        <= '0;
         wb_valid_q     <= 1'b0;
         wb_rd_q        <= 5'd0;
         wb_data_q      <= '0;
         misalign_exc_q <= 1'b0;
         bus_err_exc_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         wb_valid_q     <= 1'b0;
         bus_err_exc_q  <= 1'b0;
         misalign_exc_q <= misalign_take;

         if (data_ok && !store_q) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= load_data;
         end

         if (accept) begin
            store_q    <= ls_store;
            unsigned_q <= ls_unsigned;
            size_q     <= ls_size;
            addr_lo_q  <= addr_lo_d;
            rd_q       <= ls_rd;
            wdata_q    <= st_data;
         end

         case (state_q)
            LSU_IDLE: begin
               if (accept) state_q <= LSU_DATA;
            end
            LSU_DATA: begin
               if (d_hresp) begin
                  // An error seen together with ready is closed out immediately.
                  if (d_hready) begin
                     bus_err_exc_q <= 1'b1;
                     state_q       <= LSU_IDLE;
                  end else begin
                     state_q <= LSU_ERR;
                  end
               end else if (d_hready) begin
                  state_q <= accept ? LSU_DATA : LSU_IDLE;
               end
            end
            LSU_ERR: begin
               if (d_hready) begin
                  bus_err_exc_q <= 1'b1;
                  state_q       <= LSU_IDLE;
               end
            end
            default: state_q <= LSU_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ahb_dport.sv
// Self-checking bench for lsu_ahb_dport: directed steps plus randomized access
// streams compared against a byte-lane reference model.
module tb_lsu_ahb_dport;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ls_valid, ls_store, ls_unsigned;
   logic [1:0]  ls_size;
   logic [4:0]  ls_rd;
   logic [31:0] addr_res, st_data;
   logic [31:0] d_haddr, d_hwdata, d_hrdata;
   logic [1:0]  d_htrans;
   logic        d_hwrite;
   logic [2:0]  d_hsize;
   logic        d_hready, d_hresp;
   logic        ls_stall, wb_valid, misalign_exc, bus_err_exc;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit          store;
      logic [1:0]  size;
      bit          uns;
      logic [4:0]  rd;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] hrdata;
      int          waits;
   } acc_t;

   acc_t q[$];

   always #5 clk = ~clk;

   lsu_ahb_dport #(.AW(32), .DW(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ls_valid     (ls_valid),
      .ls_store     (ls_store),
      .ls_size      (ls_size),
      .ls_unsigned  (ls_unsigned),
      .ls_rd        (ls_rd),
      .addr_res     (addr_res),
      .st_data      (st_data),
      .d_haddr      (d_haddr),
      .d_htrans     (d_htrans),
      .d_hwrite     (d_hwrite),
      .d_hsize      (d_hsize),
      .d_hwdata     (d_hwdata),
      .d_hrdata     (d_hrdata),
      .d_hready     (d_hready),
      .d_hresp      (d_hresp),
      .ls_stall     (ls_stall),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .misalign_exc (misalign_exc),
      .bus_err_exc  (bus_err_exc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: accesses are described as byte counts and shifts.
   function automatic int nbytes(input acc_t a);
      return 1 << a.size;
   endfunction

   function automatic logic [31:0] m_haddr(input acc_t a);
      return a.addr & ~(32'(nbytes(a)) - 32'd1);
   endfunction

   function automatic logic [31:0] m_mask(input int nb);
      return (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'd1);
   endfunction

   function automatic logic [31:0] m_load(input acc_t a);
      int          nb  = nbytes(a);
      int          lo  = int'(m_haddr(a) & 32'd3);
      logic [31:0] msk = m_mask(nb);
      logic [31:0] v   = (a.hrdata >> (8 * lo)) & msk;
      if (!a.uns && nb < 4 && v[8 * nb - 1]) v = v | ~msk;
      return v;
   endfunction

   function automatic logic [31:0] m_wdata(input acc_t a);
      int          nb   = nbytes(a);
      logic [31:0] base = a.sdata & m_mask(nb);
      logic [31:0] w    = 32'd0;
      for (int i = 0; i < 4; i += nb) w = w | (base << (8 * i));
      return w;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_acc(input acc_t a);
      ls_valid    = 1'b1;
      ls_store    = a.store;
      ls_size     = a.size;
      ls_unsigned = a.uns;
      ls_rd       = a.rd;
      addr_res    = a.addr;
      st_data     = a.sdata;
   endtask

   task automatic drive_none();
      ls_valid    = 1'b0;
      ls_store    = 1'b0;
      ls_size     = 2'b00;
      ls_unsigned = 1'b0;
      ls_rd       = 5'd0;
      addr_res    = 32'd0;
      st_data     = 32'd0;
   endtask

   function automatic acc_t mk(input bit st, input logic [1:0] sz, input bit u, input logic [4:0] rd,
                               input logic [31:0] ad, input logic [31:0] sd, input logic [31:0] rdat,
                               input int w);
      acc_t a;
      a.store = st; a.size = sz; a.uns = u; a.rd = rd;
      a.addr = ad; a.sdata = sd; a.hrdata = rdat; a.waits = w;
      return a;
   endfunction

   // Plays the queued accesses back-to-back with the requested wait states.
   task automatic run_queue(input string tag);
      acc_t        pend;
      bit          pending = 0;
      int          wl = 0;
      bit          exp_wb = 0;
      logic [4:0]  exp_rd = 5'd0;
      logic [31:0] exp_data = 32'd0;
      int          stalls = 0;
      int          exp_stalls = 0;
      int          guard = 0;
      bit          hrdy, completes, accept;
      while ((q.size() > 0 || pending || exp_wb) && guard < 500) begin
         next_cycle();
         guard++;
         hrdy     = pending ? (wl == 0) : 1'($urandom_range(0, 1));
         d_hready = hrdy;
         d_hresp  = 1'b0;
         d_hrdata = pending ? pend.hrdata : $urandom;
         if (q.size() > 0) drive_acc(q[0]);
         else drive_none();
         #1;
         completes = pending && hrdy;
         accept    = (q.size() > 0) && (!pending || hrdy);
         check({tag, " wb_valid"}, 32'(wb_valid), 32'(exp_wb));
         if (exp_wb) begin
            check({tag, " wb_rd"}, 32'(wb_rd), 32'(exp_rd));
            check({tag, " wb_data"}, wb_data, exp_data);
         end
         check({tag, " ls_stall"}, 32'(ls_stall), 32'(pending && !hrdy));
         check({tag, " htrans"}, 32'(d_htrans), accept ? 32'd2 : 32'd0);
         check({tag, " misalign_exc"}, 32'(misalign_exc), 32'd0);
         check({tag, " bus_err_exc"}, 32'(bus_err_exc), 32'd0);
         if (accept) begin
            check({tag, " haddr"}, d_haddr, m_haddr(q[0]));
            check({tag, " hwrite"}, 32'(d_hwrite), 32'(q[0].store));
            check({tag, " hsize"}, 32'(d_hsize), 32'(q[0].size));
         end
         if (pending && pend.store) check({tag, " hwdata"}, d_hwdata, m_wdata(pend));
         if (ls_stall) stalls++;
         exp_wb = completes && !pend.store;
         if (exp_wb) begin
            exp_rd   = pend.rd;
            exp_data = m_load(pend);
         end
         if (pending && !hrdy) wl--;
         if (accept) begin
            pend = q.pop_front();
            pending = 1;
            wl = pend.waits;
            exp_stalls += pend.waits;
         end else if (completes) begin
            pending = 0;
         end
      end
      check({tag, " cycle budget"}, 32'(guard < 500), 32'd1);
      check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
      drive_none();
      d_hready = 1'b1;
   endtask

   initial begin
      logic [31:0] ra;
      logic [1:0]  rs;
      rst_n = 1'b0;
      drive_none();
      d_hrdata = 32'd0;
      d_hready = 1'b1;
      d_hresp  = 1'b0;

      // Reset state
      next_cycle();
      next_cycle();
      #1;
      check("reset htrans", 32'(d_htrans), 32'd0);
      check("reset stall", 32'(ls_stall), 32'd0);
      check("reset wb_valid", 32'(wb_valid), 32'd0);
      check("reset wb_data", wb_data, 32'd0);
      check("reset hwdata", d_hwdata, 32'd0);
      rst_n = 1'b1;

      // 1: word load
      q.push_back(mk(0, 2'b10, 0, 5'd5, 32'h2000_0004, 32'd0, 32'hDEAD_BEEF, 0));
      run_queue("lw");

      // 2: signed/unsigned byte and signed half
      q.push_back(mk(0, 2'b00, 0, 5'd6, 32'h2000_0003, 32'd0, 32'h8012_3456, 0));
      q.push_back(mk(0, 2'b00, 1, 5'd7, 32'h2000_0003, 32'd0, 32'h8012_3456, 0));
      q.push_back(mk(0, 2'b01, 0, 5'd8, 32'h2000_0002, 32'd0, 32'h8001_ABCD, 0));
      run_queue("lb_lbu_lh");

      // 3: half store with three wait states
      q.push_back(mk(1, 2'b01, 0, 5'd0, 32'h2000_0002, 32'h1234_ABCD, 32'd0, 3));
      run_queue("sh_wait");

      // 4: store then load, pipelined
      q.push_back(mk(1, 2'b10, 0, 5'd0, 32'h2000_0010, 32'hCAFE_0001, 32'd0, 0));
      q.push_back(mk(0, 2'b10, 0, 5'd9, 32'h2000_0014, 32'd0, 32'h0BAD_F00D, 0));
      run_queue("sw_lw");

      // Randomized aligned accesses with random wait states
      for (int i = 0; i < 40; i++) begin
         rs = 2'($urandom_range(0, 2));
         ra = $urandom & ~((32'd1 << rs) - 32'd1);
         q.push_back(mk(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), 5'($urandom),
                        ra, $urandom, $urandom, $urandom_range(0, 2)));
      end
      run_queue("random");

      // 5: misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
      next_cycle();
      drive_acc(mk(0, 2'b10, 0, 5'd4, 32'h2000_0002, 32'd0, 32'd0, 0));
      #1;
      check("mis idle htrans", 32'(d_htrans), 32'd0);
      check("mis idle stall", 32'(ls_stall), 32'd0);
      next_cycle();
      drive_none();
      #1;
      check("mis idle exc", 32'(misalign_exc), 32'd1);
      check("mis idle wb_valid", 32'(wb_valid), 32'd0);
      next_cycle();
      #1;
      check("mis idle exc pulse", 32'(misalign_exc), 32'd0);
      // Misaligned request arriving at a data-phase completion
      next_cycle();
      drive_acc(mk(0, 2'b10, 0, 5'd3, 32'h2000_0400, 32'd0, 32'd0, 0));
      #1;
      check("mis data issue", 32'(d_htrans), 32'd2);
      next_cycle();
      drive_acc(mk(0, 2'b01, 0, 5'd2, 32'h2000_0401, 32'd0, 32'd0, 0));
      d_hrdata = 32'h0102_0304;
      #1;
      check("mis data htrans", 32'(d_htrans), 32'd0);
      next_cycle();
      drive_none();
      #1;
      check("mis data exc", 32'(misalign_exc), 32'd1);
      check("mis data wb_valid", 32'(wb_valid), 32'd1);
      check("mis data wb_data", wb_data, 32'h0102_0304);
`else
      q.push_back(mk(0, 2'b10, 0, 5'd4, 32'h2000_0002, 32'd0, 32'h1122_3344, 0));
      q.push_back(mk(0, 2'b01, 0, 5'd4, 32'h2000_0003, 32'd0, 32'h8899_7766, 1));
      run_queue("aligned_fallback");
`endif

      // 6: two-cycle error response with a second access waiting
      next_cycle();
      d_hresp = 1'b0;
      d_hready = 1'b1;
      drive_acc(mk(0, 2'b10, 0, 5'd7, 32'h2000_0100, 32'd0, 32'd0, 0));
      #1;
      check("err issue htrans", 32'(d_htrans), 32'd2);
      next_cycle();
      drive_acc(mk(0, 2'b10, 0, 5'd9, 32'h2000_0200, 32'd0, 32'd0, 0));
      d_hresp = 1'b1;
      d_hready = 1'b0;
      #1;
      check("err c1 htrans", 32'(d_htrans), 32'd0);
      check("err c1 stall", 32'(ls_stall), 32'd1);
      next_cycle();
      d_hready = 1'b1;
      #1;
      check("err c2 htrans", 32'(d_htrans), 32'd0);
      check("err c2 stall", 32'(ls_stall), 32'd1);
      next_cycle();
      d_hresp = 1'b0;
      #1;
      check("err exc", 32'(bus_err_exc), 32'd1);
      check("err wb_valid", 32'(wb_valid), 32'd0);
      check("err retry htrans", 32'(d_htrans), 32'd2);
      check("err retry haddr", d_haddr, 32'h2000_0200);
      next_cycle();
      drive_none();
      d_hrdata = 32'h55AA_55AA;
      #1;
      check("err exc pulse", 32'(bus_err_exc), 32'd0);
      next_cycle();
      #1;
      check("err retry wb_valid", 32'(wb_valid), 32'd1);
      check("err retry wb_data", wb_data, 32'h55AA_55AA);
      check("err retry wb_rd", 32'(wb_rd), 32'd9);

      // Error and ready together in the data phase
      next_cycle();
      drive_acc(mk(1, 2'b10, 0, 5'd0, 32'h2000_0300, 32'h1357_9BDF, 32'd0, 0));
      #1;
      check("viol issue", 32'(d_htrans), 32'd2);
      next_cycle();
      drive_none();
      d_hresp = 1'b1;
      #1;
      check("viol stall", 32'(ls_stall), 32'd1);
      next_cycle();
      d_hresp = 1'b0;
      #1;
      check("viol exc", 32'(bus_err_exc), 32'd1);
      check("viol stall after", 32'(ls_stall), 32'd0);

      // Reset in the middle of a stalled store
      next_cycle();
      drive_acc(mk(1, 2'b10, 0, 5'd0, 32'h2000_0500, 32'hCAFE_F00D, 32'd0, 0));
      next_cycle();
      drive_none();
      d_hready = 1'b0;
      #1;
      check("rst mid hwdata", d_hwdata, 32'hCAFE_F00D);
      check("rst mid stall", 32'(ls_stall), 32'd1);
      rst_n = 1'b0;
      next_cycle();
      #1;
      check("rst after stall", 32'(ls_stall), 32'd0);
      check("rst after hwdata", d_hwdata, 32'd0);
      check("rst after htrans", 32'(d_htrans), 32'd0);
      check("rst after wb_data", wb_data, 32'd0);
      check("rst after wb_rd", 32'(wb_rd), 32'd0);
      check("rst after exc", 32'({misalign_exc, bus_err_exc, wb_valid}), 32'd0);
      rst_n = 1'b1;
      d_hready = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
